multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 79 +++++++
 rtl/multicycle_controller_alu_decoder.sv | 33 +++
 rtl/multicycle_controller.sv | 165 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller and its datapath:
// FSM states, opcodes, mux selects and ALU operation codes.
package multicycle_controller_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_e    alu_op;
  } ctrl_t;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus instruction function fields
// onto the 3-bit ALUControl code.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] ALUControl
);

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type (sub possible) from I-type (addi never subtracts)
          3'b000:  ALUControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multicycle RISC-V core with a unified
// handshaked memory (MemReady) and a sticky illegal-opcode flag.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  logic [3:0] state;
  logic [3:0] state_next;
  logic [3:0] out_state;
  logic       illegal_q;
  ctrl_t      ctrl;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE && !is_supported(op)) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (MemReady) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTER;
          OP_ITYPE:     state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_next = S_MEMWB;
      S_MEMWRITE: if (MemReady) state_next = S_FETCH;
      S_MEMWB:    state_next = S_FETCH;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_JAL:      state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // While reset is held the selects show FETCH values and every enable is gated off.
  assign out_state = reset ? state : S_FETCH;

  always_comb begin
    ctrl = '0;
    case (out_state)
      S_FETCH: begin
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.ir_write   = MemReady;
        ctrl.pc_write   = MemReady;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = Zero;
      end
      default: ctrl = '0;
    endcase
    if (!reset) begin
      ctrl.pc_write  = 1'b0;
      ctrl.ir_write  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.reg_write = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .ALUOp      (ctrl.alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .ALUControl (ALUControl)
  );

  assign PCWrite   = ctrl.pc_write;
  assign AdrSrc    = ctrl.adr_src;
  assign MemWrite  = ctrl.mem_write;
  assign IRWrite   = ctrl.ir_write;
  assign RegWrite  = ctrl.reg_write;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ImmSrc    = imm_src_of(op);
  assign Illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: decode table, directed
// multi-cycle sequences and randomized instructions against a phase-list model.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       Illegal;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Illegal    (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                P_EXECR, P_EXECI, P_ALUWB, P_JAL, P_BEQ} ph_e;

  typedef struct packed {
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    logic       ill;
  } outs_t;

  typedef struct {
    ph_e  ph;
    logic mr;
  } slot_t;

  typedef struct {
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7;
    logic [2:0] alu;
    logic [1:0] imm;
    int         len;
  } vec_t;

  int    n_pass = 0;
  int    n_total = 0;
  logic  ill_m = 1'b0;
  int    rw_cnt, mw_cnt;
  slot_t rq[$];
  vec_t  tbl[12];

  function automatic logic legal(input logic [6:0] o);
    return o inside {LW, SW, RT, IT, BQ, JL};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] funct_alu(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for one cycle spent in a given phase of an instruction.
  function automatic outs_t model(input ph_e ph, input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic z, input logic mr,
                                  input logic ill, input logic rst);
    outs_t e;
    ph_e   p;
    e     = '0;
    p     = rst ? ph : P_FETCH;
    e.imm = imm_of(o);
    e.ill = ill;
    case (p)
      P_FETCH:    begin e.sb = 2'b10; e.res = 2'b10; e.irw = mr; e.pcw = mr; end
      P_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
      P_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
      P_MEMREAD:  e.adr = 1'b1;
      P_MEMWRITE: begin e.adr = 1'b1; e.mw = 1'b1; end
      P_MEMWB:    begin e.res = 2'b01; e.rw = 1'b1; end
      P_EXECR:    begin e.sa = 2'b10; e.alu = funct_alu(1'b1, f3, f7); end
      P_EXECI:    begin e.sa = 2'b10; e.sb = 2'b01; e.alu = funct_alu(1'b0, f3, f7); end
      P_ALUWB:    e.rw = 1'b1;
      P_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      P_BEQ:      begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; end
      default:    e = '0;
    endcase
    if (!rst) begin
      e.pcw = 1'b0; e.irw = 1'b0; e.mw = 1'b0; e.rw = 1'b0;
    end
    return e;
  endfunction

  function automatic outs_t actual();
    outs_t a;
    a = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
         ImmSrc, ALUControl, Illegal};
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: drive at edge+1, compare mid-cycle, then advance.
  task automatic step(input ph_e ph, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic z, input logic mr, input logic rst, input string name);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; MemReady = mr; reset = rst;
    #4;
    check(name, 32'(actual()), 32'(model(ph, o, f3, f7, z, mr, ill_m, rst)));
    rw_cnt += int'(RegWrite);
    mw_cnt += int'(MemWrite);
    @(posedge clk); #1;
    if (!rst) ill_m = 1'b0;
    else if (ph == P_DECODE && !legal(o)) ill_m = 1'b1;
  endtask

  task automatic do_reset(input string name);
    step(P_FETCH, op, funct3, funct7b5, 1'b0, 1'b0, 1'b0, name);
  endtask

  task automatic push_wait(input ph_e ph);
    repeat ($urandom_range(0, 2)) rq.push_back('{ph, 1'b0});
    rq.push_back('{ph, 1'b1});
  endtask

  task automatic push_one(input ph_e ph);
    rq.push_back('{ph, 1'($urandom)});
  endtask

  // Phase list of an instruction follows from its class; memory phases get random stalls.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    rq.delete();
    push_wait(P_FETCH);
    push_one(P_DECODE);
    case (o)
      LW:      begin push_one(P_MEMADR); push_wait(P_MEMREAD); push_one(P_MEMWB); end
      SW:      begin push_one(P_MEMADR); push_wait(P_MEMWRITE); end
      RT:      begin push_one(P_EXECR); push_one(P_ALUWB); end
      IT:      begin push_one(P_EXECI); push_one(P_ALUWB); end
      JL:      begin push_one(P_JAL); push_one(P_ALUWB); end
      BQ:      push_one(P_BEQ);
      default: ;
    endcase
    foreach (rq[i]) step(rq[i].ph, o, f3, f7, 1'($urandom), rq[i].mr, 1'b1, "rand_cycle");
  endtask

  initial begin
    logic [6:0] ops[6];
    logic [6:0] ro;
    int         len;
    logic [2:0] alu_seen;

    ops = '{LW, SW, RT, IT, BQ, JL};
    op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b0; reset = 1'b0;
    rw_cnt = 0; mw_cnt = 0;

    tbl[0]  = '{RT, 3'b000, 1'b0, 3'b000, 2'b00, 4};
    tbl[1]  = '{RT, 3'b000, 1'b1, 3'b001, 2'b00, 4};
    tbl[2]  = '{RT, 3'b010, 1'b0, 3'b101, 2'b00, 4};
    tbl[3]  = '{RT, 3'b110, 1'b0, 3'b011, 2'b00, 4};
    tbl[4]  = '{RT, 3'b111, 1'b1, 3'b010, 2'b00, 4};
    tbl[5]  = '{RT, 3'b001, 1'b0, 3'b000, 2'b00, 4};
    tbl[6]  = '{IT, 3'b000, 1'b1, 3'b000, 2'b00, 4};
    tbl[7]  = '{IT, 3'b110, 1'b0, 3'b011, 2'b00, 4};
    tbl[8]  = '{LW, 3'b010, 1'b0, 3'b000, 2'b00, 5};
    tbl[9]  = '{SW, 3'b010, 1'b0, 3'b000, 2'b01, 4};
    tbl[10] = '{BQ, 3'b000, 1'b0, 3'b001, 2'b10, 3};
    tbl[11] = '{JL, 3'b000, 1'b0, 3'b000, 2'b11, 4};

    @(posedge clk); #1;
    do_reset("reset_state");
    do_reset("reset_hold");

    // Decode table: length, ALUControl in the third cycle, ImmSrc in FETCH.
    for (int i = 0; i < 12; i++) begin
      do_reset($sformatf("tbl%0d_reset", i));
      len = -1;
      alu_seen = 3'bxxx;
      for (int c = 0; c < 10; c++) begin
        op = tbl[i].o; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7;
        Zero = 1'b0; MemReady = 1'b1; reset = 1'b1;
        #4;
        if (c == 0) check($sformatf("tbl%0d_immsrc", i), 32'(ImmSrc), 32'(tbl[i].imm));
        if (c == 2) alu_seen = ALUControl;
        if (c > 0 && ResultSrc == 2'b10) begin
          len = c;
          break;
        end
        @(posedge clk); #1;
      end
      check($sformatf("tbl%0d_len", i), 32'(len), 32'(tbl[i].len));
      check($sformatf("tbl%0d_alu", i), 32'(alu_seen), 32'(tbl[i].alu));
      @(posedge clk); #1;
    end

    // lw with memory always ready: one RegWrite pulse in cycle 5.
    do_reset("lw_reset");
    rw_cnt = 0;
    step(P_FETCH,   LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, "lw_fetch");
    step(P_DECODE,  LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, "lw_decode");
    step(P_MEMADR,  LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, "lw_memadr");
    step(P_MEMREAD, LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, "lw_memread");
    step(P_MEMWB,   LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, "lw_memwb");
    step(P_FETCH,   LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, "lw_back_fetch");
    check("lw_regwrite_pulses", 32'(rw_cnt), 32'd1);

    // sw with three stalled MEMWRITE cycles.
    do_reset("sw_reset");
    rw_cnt = 0; mw_cnt = 0;
    step(P_FETCH,  SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, "sw_fetch");
    step(P_DECODE, SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, "sw_decode");
    step(P_MEMADR, SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, "sw_memadr");
    for (int k = 0; k < 3; k++)
      step(P_MEMWRITE, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, "sw_memwrite_wait");
    step(P_MEMWRITE, SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, "sw_memwrite_done");
    step(P_FETCH,    SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, "sw_back_fetch");
    check("sw_memwrite_cycles", 32'(mw_cnt), 32'd4);
    check("sw_regwrite_cycles", 32'(rw_cnt), 32'd0);

    // beq taken then not taken, three cycles each.
    do_reset("beq_reset");
    for (int t = 0; t < 2; t++) begin
      step(P_FETCH,  BQ, 3'b000, 1'b0, 1'(t == 0), 1'b1, 1'b1, "beq_fetch");
      step(P_DECODE, BQ, 3'b000, 1'b0, 1'(t == 0), 1'b1, 1'b1, "beq_decode");
      #4;
      check($sformatf("beq%0d_pcwrite", t), 32'(PCWrite), 32'(t == 0));
      @(posedge clk); #1;
    end
    step(P_FETCH, BQ, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, "beq_back_fetch");

    // Unsupported opcode: no enables, Illegal sticks until reset.
    do_reset("ill_reset");
    step(P_FETCH,  7'h7F, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, "ill_fetch");
    step(P_DECODE, 7'h7F, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, "ill_decode");
    #4;
    check("ill_flag_set", 32'(Illegal), 32'd1);
    step(P_FETCH,  7'h7F, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, "ill_fetch_after");
    step(P_FETCH,  7'h7F, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, "ill_still_set");
    do_reset("ill_clear_reset");
    #4;
    check("ill_flag_cleared", 32'(Illegal), 32'd0);
    @(posedge clk); #1;
    do_reset("ill_realign");

    // Reset asserted while MEMWRITE waits on memory.
    step(P_FETCH,    SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, "rst_sw_fetch");
    step(P_DECODE,   SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, "rst_sw_decode");
    step(P_MEMADR,   SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, "rst_sw_memadr");
    step(P_MEMWRITE, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, "rst_sw_wait");
    step(P_MEMWRITE, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, "rst_sw_reset_low");
    step(P_FETCH,    SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, "rst_sw_first_fetch");
    do_reset("rand_reset");

    // Randomized instruction stream, including illegal opcodes and occasional resets.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) >= 6) begin
        ro = 7'($urandom);
        while (legal(ro)) ro = 7'($urandom);
      end else begin
        ro = ops[$urandom_range(0, 5)];
      end
      run_instr(ro, 3'($urandom), 1'($urandom));
      if ($urandom_range(0, 19) == 0) do_reset("rand_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
